cpu_mc_param: RTL and testbench

Parametrised multi-cycle successor to the fixed 5-bit/8-word CPU.
- Data width, memory depth and register count are parameters.
- Instruction execution is sequenced by an explicit FSM and takes 2 cycles per instruction.
- Adds LOAD, LDI, conditional/unconditional jumps, a valid/ready input handshake, a valid-pulsed output and HALT.
- Program is written through the loader port while stopped, then executed under `run`.

---
 rtl/cpu_mc_pkg.sv | 61 ++++++
 rtl/cpu_mc_alu.sv | 35 +++
 rtl/cpu_mc_param.sv | 169 ++++++++++++++++
 tb/tb_cpu_mc_param.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the parametrised multi-cycle CPU: opcodes, FSM states,
// instruction field extraction and rotate helpers.
package cpu_mc_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_JG    = 4'd3;
    localparam logic [3:0] OP_JE    = 4'd4;
    localparam logic [3:0] OP_JMP   = 4'd5;
    localparam logic [3:0] OP_ROL   = 4'd6;
    localparam logic [3:0] OP_ROR   = 4'd7;
    localparam logic [3:0] OP_CMP   = 4'd8;
    localparam logic [3:0] OP_SUB   = 4'd9;
    localparam logic [3:0] OP_AND   = 4'd10;
    localparam logic [3:0] OP_ADD   = 4'd11;
    localparam logic [3:0] OP_IN    = 4'd12;
    localparam logic [3:0] OP_OUT   = 4'd13;
    localparam logic [3:0] OP_LDI   = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_WAIT_IN,
        ST_HALT
    } state_t;

    // Layout from MSB: op(4) | rd(ra_w) | rs(ra_w) | a(addr_w)
    function automatic logic [3:0] fld_op(input logic [31:0] instr, input int instr_w);
        return 4'((instr >> (instr_w - 4)) & 32'hF);
    endfunction

    function automatic logic [31:0] fld_rd(input logic [31:0] instr, input int ra_w,
                                           input int addr_w);
        return (instr >> (ra_w + addr_w)) & ((32'd1 << ra_w) - 32'd1);
    endfunction

    function automatic logic [31:0] fld_rs(input logic [31:0] instr, input int ra_w,
                                           input int addr_w);
        return (instr >> addr_w) & ((32'd1 << ra_w) - 32'd1);
    endfunction

    function automatic logic [31:0] fld_a(input logic [31:0] instr, input int addr_w);
        return instr & ((32'd1 << addr_w) - 32'd1);
    endfunction

    // Rotate the low w bits of x left by n (0 <= n < w); upper bits come back zero.
    function automatic logic [63:0] rol_w(input logic [63:0] x, input int w, input int n);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (n == 0)
            return x & mask;
        return ((x << n) | (x >> (w - n))) & mask;
    endfunction

    function automatic logic [63:0] ror_w(input logic [63:0] x, input int w, input int n);
        return rol_w(x, w, (w - n) % w);
    endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational datapath for ADD/SUB/AND/ROL/ROR plus unsigned compare flags.
module cpu_mc_alu
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 5
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a_val,
    input  logic [DATA_W-1:0] b_val,
    output logic [DATA_W-1:0] result,
    output logic              gt,
    output logic              eq
);

    int amt;

    // For rotates b_val carries the immediate; amount is taken modulo the width.
    assign amt = int'(b_val) % DATA_W;

    always_comb begin
        result = a_val;
        unique case (op)
            OP_ADD:  result = a_val + b_val;
            OP_SUB:  result = a_val - b_val;
            OP_AND:  result = a_val & b_val;
            OP_ROL:  result = DATA_W'(rol_w(64'(a_val), DATA_W, amt));
            OP_ROR:  result = DATA_W'(ror_w(64'(a_val), DATA_W, amt));
            default: result = a_val;
        endcase
    end

    assign gt = (a_val > b_val);
    assign eq = (a_val == b_val);

endmodule

// File: rtl/cpu_mc_param.sv
// Parametrised multi-cycle CPU: FETCH/EXEC sequencing, register file, program
// memory with loader port, valid/ready input and pulsed output.
module cpu_mc_param
    import cpu_mc_pkg::*;
#(
    parameter  int DATA_W  = 5,
    parameter  int ADDR_W  = 3,
    parameter  int NREG    = 4,
    localparam int RA_W    = $clog2(NREG),
    localparam int INSTR_W = 4 + 2*RA_W + ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               halted,
    output logic               flag_gt,
    output logic               flag_eq
);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg;
    logic [INSTR_W-1:0]  ir_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic                out_valid_reg;
    logic                gt_reg, eq_reg;
    logic [DATA_W-1:0]   regs [NREG];
    logic [INSTR_W-1:0]  mem [2**ADDR_W];

    logic [3:0]          op;
    logic [RA_W-1:0]     rd_idx, rs_idx;
    logic [ADDR_W-1:0]   a_fld;
    logic [DATA_W-1:0]   imm, rd_val, rs_val, alu_b, alu_res, load_val;
    logic [INSTR_W-1:0]  store_word;
    logic                alu_gt, alu_eq, jump_taken, load_ok;

    assign op     = fld_op(32'(ir_reg), INSTR_W);
    assign rd_idx = RA_W'(fld_rd(32'(ir_reg), RA_W, ADDR_W));
    assign rs_idx = RA_W'(fld_rs(32'(ir_reg), RA_W, ADDR_W));
    assign a_fld  = ADDR_W'(fld_a(32'(ir_reg), ADDR_W));

    // Size casts give zero-extension or truncation in either direction.
    assign imm        = DATA_W'(a_fld);
    assign rd_val     = regs[rd_idx];
    assign rs_val     = regs[rs_idx];
    assign load_val   = DATA_W'(mem[a_fld]);
    assign store_word = INSTR_W'(rd_val);
    assign alu_b      = (op == OP_ROL || op == OP_ROR) ? imm : rs_val;

    assign jump_taken = (op == OP_JMP) || (op == OP_JG && gt_reg) || (op == OP_JE && eq_reg);
    assign load_ok    = (state_reg == ST_FETCH && !run) || (state_reg == ST_HALT);

    cpu_mc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a_val  (rd_val),
        .b_val  (alu_b),
        .result (alu_res),
        .gt     (alu_gt),
        .eq     (alu_eq)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= ST_FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        halted     = 1'b0;
        unique case (state_reg)
            ST_FETCH: begin
                if (run)
                    state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (op == OP_IN)
                    state_next = ST_WAIT_IN;
                else if (op == OP_HALT)
                    state_next = ST_HALT;
                else
                    state_next = ST_FETCH;
            end
            ST_WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg        <= '0;
            ir_reg        <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            gt_reg        <= 1'b0;
            eq_reg        <= 1'b0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            unique case (state_reg)
                ST_FETCH: begin
                    if (run) begin
                        ir_reg <= mem[pc_reg];
                        pc_reg <= pc_reg + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (jump_taken)
                        pc_reg <= a_fld;
                    unique case (op)
                        OP_LOAD: regs[rd_idx] <= load_val;
                        OP_LDI:  regs[rd_idx] <= imm;
                        OP_ROL, OP_ROR, OP_SUB, OP_AND, OP_ADD:
                            regs[rd_idx] <= alu_res;
                        OP_CMP: begin
                            gt_reg <= alu_gt;
                            eq_reg <= alu_eq;
                        end
                        OP_OUT: begin
                            out_data_reg  <= rd_val;
                            out_valid_reg <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT_IN: begin
                    if (in_valid)
                        regs[rd_idx] <= in_data;
                end
                default: ;
            endcase
        end
    end

    // Program memory is deliberately outside reset so a loaded program survives it.
    always_ff @(posedge clk) begin
        if (load_we && load_ok)
            mem[load_addr] <= load_data;
        else if (state_reg == ST_EXEC && op == OP_STORE)
            mem[a_fld] <= store_word;
    end

    assign pc        = pc_reg;
    assign ir        = ir_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign flag_gt   = gt_reg;
    assign flag_eq   = eq_reg;

endmodule

// File: tb/tb_cpu_mc_param.sv
// Directed bench for cpu_mc_param: default-parameter core plus an 8-bit/16-word/8-reg core.
module tb_cpu_mc_param;

    localparam int I_NOP = 0, I_LOAD = 1, I_STORE = 2, I_JG = 3, I_JE = 4, I_JMP = 5;
    localparam int I_ROL = 6, I_ROR = 7, I_CMP = 8, I_SUB = 9, I_AND = 10, I_ADD = 11;
    localparam int I_IN = 12, I_OUT = 13, I_LDI = 14, I_HALT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter core
    logic        reset = 1'b1, run = 1'b0, load_we = 1'b0, in_valid = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [10:0] load_data = '0;
    logic [4:0]  in_data = '0;
    logic        in_ready, out_valid, halted, flag_gt, flag_eq;
    logic [4:0]  out_data;
    logic [2:0]  pc;
    logic [10:0] ir;

    // wide core
    logic        b_reset = 1'b1, b_run = 1'b0, b_load_we = 1'b0, b_in_valid = 1'b0;
    logic [3:0]  b_load_addr = '0;
    logic [13:0] b_load_data = '0;
    logic [7:0]  b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_halted, b_flag_gt, b_flag_eq;
    logic [7:0]  b_out_data;
    logic [3:0]  b_pc;
    logic [13:0] b_ir;

    cpu_mc_param u_dut (
        .clk(clk), .reset(reset), .run(run), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .pc(pc), .ir(ir), .halted(halted),
        .flag_gt(flag_gt), .flag_eq(flag_eq)
    );

    cpu_mc_param #(.DATA_W(8), .ADDR_W(4), .NREG(8)) u_dut8 (
        .clk(clk), .reset(b_reset), .run(b_run), .load_we(b_load_we), .load_addr(b_load_addr),
        .load_data(b_load_data), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .pc(b_pc),
        .ir(b_ir), .halted(b_halted), .flag_gt(b_flag_gt), .flag_eq(b_flag_eq)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] outs_a[$];
    logic [31:0] outs_b[$];

    always @(negedge clk) begin
        if (out_valid === 1'b1)   outs_a.push_back(32'(out_data));
        if (b_out_valid === 1'b1) outs_b.push_back(32'(b_out_data));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] e5(input int op, input int rd, input int rs, input int a);
        return {4'(op), 2'(rd), 2'(rs), 3'(a)};
    endfunction

    function automatic logic [13:0] e8(input int op, input int rd, input int rs, input int a);
        return {4'(op), 3'(rd), 3'(rs), 4'(a)};
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size())
            return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input int addr, input logic [10:0] data);
        load_addr = 3'(addr);
        load_data = data;
        load_we   = 1'b1;
        tick(1);
        load_we   = 1'b0;
    endtask

    task automatic wr_b(input int addr, input logic [13:0] data);
        b_load_addr = 4'(addr);
        b_load_data = data;
        b_load_we   = 1'b1;
        tick(1);
        b_load_we   = 1'b0;
    endtask

    task automatic reset_a();
        run = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        outs_a.delete();
    endtask

    // Bounded run; an expired budget shows up as a halted miscompare.
    task automatic run_until_halt(input string tag, input bit wide, input int max_cyc);
        int i = 0;
        if (wide) b_run = 1'b1; else run = 1'b1;
        while (((wide ? b_halted : halted) !== 1'b1) && i < max_cyc) begin
            tick(1);
            i++;
        end
        if (wide) b_run = 1'b0; else run = 1'b0;
        check(tag, 32'(wide ? b_halted : halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values ----
        tick(1);
        check("rst_pc", 32'(pc), 0);
        check("rst_ir", 32'(ir), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_flags", 32'({flag_gt, flag_eq}), 0);
        reset = 1'b0;
        b_reset = 1'b0;

        // ---- basic program ----
        wr_a(0, e5(I_LOAD, 0, 0, 7));
        wr_a(1, e5(I_LDI, 1, 0, 2));
        wr_a(2, e5(I_ADD, 0, 1, 0));
        wr_a(3, e5(I_STORE, 0, 0, 6));
        wr_a(4, e5(I_OUT, 0, 0, 0));
        wr_a(5, e5(I_HALT, 0, 0, 0));
        wr_a(7, 11'd3);
        outs_a.delete();
        run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (c == 10) check("basic_out_pulse", 32'(out_valid), 1);
            if (c == 10) check("basic_out_data", 32'(out_data), 5);
            if (c == 11) check("basic_out_pulse_end", 32'(out_valid), 0);
            if (c == 11) check("basic_not_halted_yet", 32'(halted), 0);
        end
        check("basic_halted", 32'(halted), 1);
        check("basic_pc", 32'(pc), 6);
        check("basic_ir", 32'(ir), 32'(e5(I_HALT, 0, 0, 0)));
        check("basic_mem6", 32'(u_dut.mem[6]), 5);
        tick(3);
        check("halt_sticky", 32'(halted), 1);
        check("halt_pc_frozen", 32'(pc), 6);
        check("out_data_held", 32'(out_data), 5);
        run = 1'b0;
        check("basic_pulse_count", 32'(outs_a.size()), 1);

        // ---- rotates ----
        reset_a();
        wr_a(0, e5(I_LOAD, 0, 0, 7));
        wr_a(1, e5(I_ROL, 0, 0, 2));
        wr_a(2, e5(I_OUT, 0, 0, 0));
        wr_a(3, e5(I_LOAD, 0, 0, 7));
        wr_a(4, e5(I_ROL, 0, 0, 7));
        wr_a(5, e5(I_OUT, 0, 0, 0));
        wr_a(6, e5(I_HALT, 0, 0, 0));
        wr_a(7, 11'b10011);
        run_until_halt("rot_halt", 1'b0, 40);
        check("rol2", q_at(outs_a, 0), 32'b01110);
        check("rol7", q_at(outs_a, 1), 32'b01110);
        reset_a();
        wr_a(0, e5(I_LDI, 1, 0, 1));
        wr_a(1, e5(I_ROR, 1, 0, 1));
        wr_a(2, e5(I_OUT, 1, 0, 0));
        wr_a(3, e5(I_HALT, 0, 0, 0));
        run_until_halt("ror_halt", 1'b0, 40);
        check("ror1", q_at(outs_a, 0), 32'b10000);

        // ---- input handshake ----
        reset_a();
        wr_a(0, e5(I_IN, 2, 0, 0));
        wr_a(1, e5(I_OUT, 2, 0, 0));
        wr_a(2, e5(I_HALT, 0, 0, 0));
        run = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            check("in_ready_wait", 32'(in_ready), 1);
            check("in_pc_frozen", 32'(pc), 1);
            tick(1);
        end
        in_data = 5'b10101;
        in_valid = 1'b1;
        tick(1);
        check("in_ready_drop", 32'(in_ready), 0);
        in_valid = 1'b0;
        run_until_halt("in_halt", 1'b0, 40);
        check("in_value", q_at(outs_a, 0), 21);

        // ---- compare/branch loop, loop body patched while stopped ----
        reset_a();
        wr_a(0, e5(I_LDI, 0, 0, 3));
        wr_a(1, e5(I_LDI, 2, 0, 1));
        run = 1'b1;
        tick(4);
        run = 1'b0;
        tick(1);
        check("loop_init_pc", 32'(pc), 2);
        wr_a(2, e5(I_CMP, 0, 1, 0));
        wr_a(3, e5(I_JG, 0, 0, 6));
        wr_a(4, e5(I_OUT, 3, 0, 0));
        wr_a(5, e5(I_HALT, 0, 0, 0));
        wr_a(6, e5(I_SUB, 0, 2, 0));
        wr_a(7, e5(I_NOP, 0, 0, 0));
        wr_a(0, e5(I_ADD, 3, 2, 0));
        wr_a(1, e5(I_JMP, 0, 0, 2));
        check("loop_pc_held", 32'(pc), 2);
        run_until_halt("loop_halt", 1'b0, 120);
        check("loop_taken_jg", q_at(outs_a, 0), 3);
        check("loop_outs", 32'(outs_a.size()), 1);
        check("loop_flags", 32'({flag_gt, flag_eq}), 32'b01);

        // ---- reset in WAIT_IN ----
        reset_a();
        wr_a(0, e5(I_IN, 1, 0, 0));
        wr_a(1, e5(I_OUT, 1, 0, 0));
        wr_a(2, e5(I_HALT, 0, 0, 0));
        run = 1'b1;
        tick(2);
        check("wait_in_ready", 32'(in_ready), 1);
        in_data = 5'd9;
        in_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 0);
        check("arst_pc", 32'(pc), 0);
        check("arst_ir", 32'(ir), 0);
        tick(1);
        run = 1'b0;
        in_valid = 1'b0;
        reset = 1'b0;
        check("arst_no_input", 32'(u_dut.regs[1]), 0);
        check("arst_mem_kept", 32'(u_dut.mem[0]), 32'(e5(I_IN, 1, 0, 0)));

        // ---- reset in EXEC of STORE, then loader while running ----
        wr_a(0, e5(I_LDI, 0, 0, 5));
        wr_a(1, e5(I_STORE, 0, 0, 6));
        wr_a(6, 11'd2);
        run = 1'b1;
        tick(3);
        run = 1'b0;
        check("store_in_exec_ir", 32'(ir), 32'(e5(I_STORE, 0, 0, 6)));
        reset = 1'b1;
        #1;
        check("srst_pc", 32'(pc), 0);
        check("srst_ir", 32'(ir), 0);
        check("srst_halted", 32'(halted), 0);
        tick(1);
        reset = 1'b0;
        check("srst_store_dropped", 32'(u_dut.mem[6]), 2);
        check("srst_mem_kept", 32'(u_dut.mem[1]), 32'(e5(I_STORE, 0, 0, 6)));
        run = 1'b1;
        load_addr = 3'd6;
        load_data = 11'd7;
        load_we = 1'b1;
        tick(1);
        load_we = 1'b0;
        run = 1'b0;
        tick(2);
        check("loader_ignored_run", 32'(u_dut.mem[6]), 2);

        // ---- wide core ----
        wr_b(0, e8(I_LOAD, 1, 0, 9));
        wr_b(1, e8(I_LOAD, 2, 0, 10));
        wr_b(2, e8(I_ADD, 1, 2, 0));
        wr_b(3, e8(I_OUT, 1, 0, 0));
        wr_b(4, e8(I_JMP, 0, 0, 12));
        wr_b(5, e8(I_OUT, 2, 0, 0));
        wr_b(6, e8(I_HALT, 0, 0, 0));
        wr_b(9, 14'd200);
        wr_b(10, 14'd100);
        wr_b(12, e8(I_LDI, 3, 0, 15));
        wr_b(13, e8(I_OUT, 3, 0, 0));
        wr_b(14, e8(I_HALT, 0, 0, 0));
        outs_b.delete();
        run_until_halt("w_halt", 1'b1, 60);
        check("w_add_wrap", q_at(outs_b, 0), 44);
        check("w_ldi15", q_at(outs_b, 1), 15);
        check("w_outs", 32'(outs_b.size()), 2);
        check("w_pc", 32'(b_pc), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
